// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, arbiter state, beat helper.
// Used by the two-client A-channel arbiter (optional TL_ARB_PERF_EN).
package tl_ul_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int CSRC_W = 5;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Returns beats-1; only Puts wider than one 8-byte beat are bursts.
  function automatic logic [2:0] tl_beats(
    input logic [2:0] opcode,
    input logic [2:0] size
  );
    logic [2:0] r;
    r = 3'd0;
    if ((opcode == PUT_FULL || opcode == PUT_PARTIAL)
        && size > 3'd3) begin
      unique case (size)
        3'd4:    r = 3'd1;
        3'd5:    r = 3'd3;
        default: r = 3'd7;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_rr_grant2.sv
// Two-way round-robin picker: prio names the client that wins a tie.
// Part of tl_ul_a_arbiter_2 (optional TL_ARB_PERF_EN in top).
module tl_rr_grant2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       any
);

  assign any = |valid;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): grant = prio;
      (valid == 2'b10): grant = 1'b1;
      default:          grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tl_ul_a_arbiter_2.sv
// Two-client TileLink-UL arbiter: round-robin A with Put burst lock, D by tag.
// Define TL_ARB_PERF_EN to add saturating grant/contention counters.
module tl_ul_a_arbiter_2
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W = tl_ul_pkg::ADDR_W,
  parameter int DATA_W = tl_ul_pkg::DATA_W,
  parameter int CSRC_W = tl_ul_pkg::CSRC_W
) (
  input  logic                clock,
  input  logic                reset,

  output logic                in0_a_ready,
  input  logic                in0_a_valid,
  input  logic [2:0]          in0_a_bits_opcode,
  input  logic [2:0]          in0_a_bits_param,
  input  logic [2:0]          in0_a_bits_size,
  input  logic [CSRC_W-1:0]   in0_a_bits_source,
  input  logic [ADDR_W-1:0]   in0_a_bits_address,
  input  logic [DATA_W/8-1:0] in0_a_bits_mask,
  input  logic [DATA_W-1:0]   in0_a_bits_data,
  input  logic                in0_a_bits_corrupt,
  input  logic                in0_d_ready,
  output logic                in0_d_valid,
  output logic [2:0]          in0_d_bits_opcode,
  output logic [1:0]          in0_d_bits_param,
  output logic [2:0]          in0_d_bits_size,
  output logic [CSRC_W-1:0]   in0_d_bits_source,
  output logic                in0_d_bits_sink,
  output logic                in0_d_bits_denied,
  output logic [DATA_W-1:0]   in0_d_bits_data,
  output logic                in0_d_bits_corrupt,

  output logic                in1_a_ready,
  input  logic                in1_a_valid,
  input  logic [2:0]          in1_a_bits_opcode,
  input  logic [2:0]          in1_a_bits_param,
  input  logic [2:0]          in1_a_bits_size,
  input  logic [CSRC_W-1:0]   in1_a_bits_source,
  input  logic [ADDR_W-1:0]   in1_a_bits_address,
  input  logic [DATA_W/8-1:0] in1_a_bits_mask,
  input  logic [DATA_W-1:0]   in1_a_bits_data,
  input  logic                in1_a_bits_corrupt,
  input  logic                in1_d_ready,
  output logic                in1_d_valid,
  output logic [2:0]          in1_d_bits_opcode,
  output logic [1:0]          in1_d_bits_param,
  output logic [2:0]          in1_d_bits_size,
  output logic [CSRC_W-1:0]   in1_d_bits_source,
  output logic                in1_d_bits_sink,
  output logic                in1_d_bits_denied,
  output logic [DATA_W-1:0]   in1_d_bits_data,
  output logic                in1_d_bits_corrupt,

  input  logic                out_a_ready,
  output logic                out_a_valid,
  output logic [2:0]          out_a_bits_opcode,
  output logic [2:0]          out_a_bits_param,
  output logic [2:0]          out_a_bits_size,
  output logic [CSRC_W:0]     out_a_bits_source,
  output logic [ADDR_W-1:0]   out_a_bits_address,
  output logic [DATA_W/8-1:0] out_a_bits_mask,
  output logic [DATA_W-1:0]   out_a_bits_data,
  output logic                out_a_bits_corrupt,

  output logic                out_d_ready,
  input  logic                out_d_valid,
  input  logic [2:0]          out_d_bits_opcode,
  input  logic [1:0]          out_d_bits_param,
  input  logic [2:0]          out_d_bits_size,
  input  logic [CSRC_W:0]     out_d_bits_source,
  input  logic                out_d_bits_sink,
  input  logic                out_d_bits_denied,
  input  logic [DATA_W-1:0]   out_d_bits_data,
  input  logic                out_d_bits_corrupt
`ifdef TL_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grants0,
  output logic [31:0]         perf_grants1,
  output logic [31:0]         perf_contend
`endif
);

  arb_state_e state;
  logic       prio;
  logic       owner;
  logic [2:0] beats_left;

  logic [1:0] a_valid;
  logic       pick;
  logic       any_valid;
  logic       sel;
  logic       a_fire;
  logic [2:0] first_beats;
  logic       d_idx;

  assign a_valid = {in1_a_valid, in0_a_valid};

  tl_rr_grant2 u_pick (
    .valid (a_valid),
    .prio  (prio),
    .grant (pick),
    .any   (any_valid)
  );

  // While locked the owner is forwarded even if it drops valid.
  assign sel = (state == LOCKED) ? owner : pick;

  assign out_a_valid = (state == LOCKED) ? a_valid[owner]
                                         : any_valid;

  assign out_a_bits_opcode  = sel ? in1_a_bits_opcode
                                  : in0_a_bits_opcode;
  assign out_a_bits_param   = sel ? in1_a_bits_param
                                  : in0_a_bits_param;
  assign out_a_bits_size    = sel ? in1_a_bits_size
                                  : in0_a_bits_size;
  assign out_a_bits_source  = sel ? {1'b1, in1_a_bits_source}
                                  : {1'b0, in0_a_bits_source};
  assign out_a_bits_address = sel ? in1_a_bits_address
                                  : in0_a_bits_address;
  assign out_a_bits_mask    = sel ? in1_a_bits_mask
                                  : in0_a_bits_mask;
  assign out_a_bits_data    = sel ? in1_a_bits_data
                                  : in0_a_bits_data;
  assign out_a_bits_corrupt = sel ? in1_a_bits_corrupt
                                  : in0_a_bits_corrupt;

  assign in0_a_ready = out_a_ready & ~sel;
  assign in1_a_ready = out_a_ready &  sel;

  assign a_fire      = out_a_valid & out_a_ready;
  assign first_beats = tl_beats(out_a_bits_opcode, out_a_bits_size);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      beats_left <= 3'd0;
    end else if (a_fire) begin
      unique case (state)
        IDLE: begin
          prio <= ~pick;
          if (first_beats != 3'd0) begin
            state      <= LOCKED;
            owner      <= pick;
            beats_left <= first_beats;
          end
        end
        LOCKED: begin
          beats_left <= beats_left - 3'd1;
          if (beats_left == 3'd1) state <= IDLE;
        end
      endcase
    end
  end

  // Responses are steered per beat by the tag bit added on the A side.
  assign d_idx       = out_d_bits_source[CSRC_W];
  assign in0_d_valid = out_d_valid & ~d_idx;
  assign in1_d_valid = out_d_valid &  d_idx;
  assign out_d_ready = d_idx ? in1_d_ready : in0_d_ready;

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[CSRC_W-1:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;

  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[CSRC_W-1:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

`ifdef TL_ARB_PERF_EN
  logic first_fire;
  logic contend;

  assign first_fire = a_fire & (state == IDLE);
  assign contend    = (&a_valid) & (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_grants0 <= 32'd0;
      perf_grants1 <= 32'd0;
      perf_contend <= 32'd0;
    end else begin
      if (first_fire && !pick && perf_grants0 != '1)
        perf_grants0 <= perf_grants0 + 32'd1;
      if (first_fire && pick && perf_grants1 != '1)
        perf_grants1 <= perf_grants1 + 32'd1;
      if (contend && perf_contend != '1)
        perf_contend <= perf_contend + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter_2.sv
// Bench for tl_ul_a_arbiter_2: directed scenarios plus random traffic
// against a transaction-level model (perf checks when TL_ARB_PERF_EN).
module tb_tl_ul_a_arbiter_2;
  import tl_ul_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        a_v[2];
  logic [2:0]  a_op[2], a_par[2], a_sz[2];
  logic [4:0]  a_src[2];
  logic [28:0] a_adr[2];
  logic [7:0]  a_msk[2];
  logic [63:0] a_dat[2];
  logic        a_cor[2];
  logic        d_rdy[2];

  logic        out_a_ready, out_d_valid;
  logic [2:0]  d_op, d_sz;
  logic [1:0]  d_par;
  logic [5:0]  d_src;
  logic        d_sink, d_den, d_cor;
  logic [63:0] d_dat;

  logic        in0_a_ready, in1_a_ready, out_a_valid, out_d_ready;
  logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
  logic [5:0]  out_a_bits_source;
  logic [28:0] out_a_bits_address;
  logic [7:0]  out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic        out_a_bits_corrupt;

  logic        in0_d_valid, in1_d_valid;
  logic [2:0]  in0_d_bits_opcode, in1_d_bits_opcode;
  logic [1:0]  in0_d_bits_param, in1_d_bits_param;
  logic [2:0]  in0_d_bits_size, in1_d_bits_size;
  logic [4:0]  in0_d_bits_source, in1_d_bits_source;
  logic        in0_d_bits_sink, in1_d_bits_sink;
  logic        in0_d_bits_denied, in1_d_bits_denied;
  logic [63:0] in0_d_bits_data, in1_d_bits_data;
  logic        in0_d_bits_corrupt, in1_d_bits_corrupt;
`ifdef TL_ARB_PERF_EN
  logic [31:0] perf_grants0, perf_grants1, perf_contend;
`endif

  tl_ul_a_arbiter_2 dut (
    .clock(clock), .reset(reset),
    .in0_a_ready(in0_a_ready), .in0_a_valid(a_v[0]),
    .in0_a_bits_opcode(a_op[0]), .in0_a_bits_param(a_par[0]),
    .in0_a_bits_size(a_sz[0]), .in0_a_bits_source(a_src[0]),
    .in0_a_bits_address(a_adr[0]), .in0_a_bits_mask(a_msk[0]),
    .in0_a_bits_data(a_dat[0]), .in0_a_bits_corrupt(a_cor[0]),
    .in0_d_ready(d_rdy[0]), .in0_d_valid(in0_d_valid),
    .in0_d_bits_opcode(in0_d_bits_opcode),
    .in0_d_bits_param(in0_d_bits_param),
    .in0_d_bits_size(in0_d_bits_size),
    .in0_d_bits_source(in0_d_bits_source),
    .in0_d_bits_sink(in0_d_bits_sink),
    .in0_d_bits_denied(in0_d_bits_denied),
    .in0_d_bits_data(in0_d_bits_data),
    .in0_d_bits_corrupt(in0_d_bits_corrupt),
    .in1_a_ready(in1_a_ready), .in1_a_valid(a_v[1]),
    .in1_a_bits_opcode(a_op[1]), .in1_a_bits_param(a_par[1]),
    .in1_a_bits_size(a_sz[1]), .in1_a_bits_source(a_src[1]),
    .in1_a_bits_address(a_adr[1]), .in1_a_bits_mask(a_msk[1]),
    .in1_a_bits_data(a_dat[1]), .in1_a_bits_corrupt(a_cor[1]),
    .in1_d_ready(d_rdy[1]), .in1_d_valid(in1_d_valid),
    .in1_d_bits_opcode(in1_d_bits_opcode),
    .in1_d_bits_param(in1_d_bits_param),
    .in1_d_bits_size(in1_d_bits_size),
    .in1_d_bits_source(in1_d_bits_source),
    .in1_d_bits_sink(in1_d_bits_sink),
    .in1_d_bits_denied(in1_d_bits_denied),
    .in1_d_bits_data(in1_d_bits_data),
    .in1_d_bits_corrupt(in1_d_bits_corrupt),
    .out_a_ready(out_a_ready), .out_a_valid(out_a_valid),
    .out_a_bits_opcode(out_a_bits_opcode),
    .out_a_bits_param(out_a_bits_param),
    .out_a_bits_size(out_a_bits_size),
    .out_a_bits_source(out_a_bits_source),
    .out_a_bits_address(out_a_bits_address),
    .out_a_bits_mask(out_a_bits_mask),
    .out_a_bits_data(out_a_bits_data),
    .out_a_bits_corrupt(out_a_bits_corrupt),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid),
    .out_d_bits_opcode(d_op), .out_d_bits_param(d_par),
    .out_d_bits_size(d_sz), .out_d_bits_source(d_src),
    .out_d_bits_sink(d_sink), .out_d_bits_denied(d_den),
    .out_d_bits_data(d_dat), .out_d_bits_corrupt(d_cor)
`ifdef TL_ARB_PERF_EN
    ,
    .perf_grants0(perf_grants0),
    .perf_grants1(perf_grants1),
    .perf_contend(perf_contend)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: a burst is a number of fires still owed.
  bit m_lock, m_owner, m_prio;
  int m_left;
  int m_g[2];
  int m_cont;

  function automatic int beats(logic [2:0] op, logic [2:0] sz);
    if (op <= 3'd1 && sz > 3'd3) return 1 << (int'(sz) - 3);
    return 1;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_prio = 0; m_left = 0;
    m_g[0] = 0; m_g[1] = 0; m_cont = 0;
  endtask

  task automatic cycle();
    bit [1:0] v;
    bit w, ov, idx;
    int b;
    #1;
    v = {a_v[1], a_v[0]};
    if (!reset) model_reset();
    if (m_lock) begin
      w = m_owner; ov = v[w];
    end else begin
      ov = |v;
      w = (v == 2'b11) ? m_prio : (v == 2'b10);
    end
    check("a_valid", out_a_valid, ov);
    if (ov) begin
      check("a_src", out_a_bits_source, {w, a_src[w]});
      check("a_adr", out_a_bits_address, a_adr[w]);
      check("a_dat", out_a_bits_data, a_dat[w]);
      check("a_misc",
        {out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
         out_a_bits_mask, out_a_bits_corrupt},
        {a_op[w], a_par[w], a_sz[w], a_msk[w], a_cor[w]});
    end
    if (v[0]) check("a_rdy0", in0_a_ready, out_a_ready && w == 0);
    if (v[1]) check("a_rdy1", in1_a_ready, out_a_ready && w == 1);
    idx = d_src[5];
    check("d_vld", {in1_d_valid, in0_d_valid},
          {out_d_valid && idx, out_d_valid && !idx});
    check("d_rdy", out_d_ready, d_rdy[idx]);
    check("d_src", {in1_d_bits_source, in0_d_bits_source},
          {d_src[4:0], d_src[4:0]});
    check("d_dat0", in0_d_bits_data, d_dat);
    check("d_dat1", in1_d_bits_data, d_dat);
    check("d_misc",
      {in0_d_bits_opcode, in0_d_bits_param, in0_d_bits_size,
       in0_d_bits_sink, in0_d_bits_denied, in0_d_bits_corrupt,
       in1_d_bits_opcode, in1_d_bits_param, in1_d_bits_size,
       in1_d_bits_sink, in1_d_bits_denied, in1_d_bits_corrupt},
      {2{d_op, d_par, d_sz, d_sink, d_den, d_cor}});
    if (reset) begin
      if (!m_lock && v == 2'b11) m_cont++;
      if (ov && out_a_ready) begin
        if (!m_lock) begin
          m_g[w]++;
          m_prio = !w;
          b = beats(a_op[w], a_sz[w]);
          if (b > 1) begin
            m_lock = 1; m_owner = w; m_left = b - 1;
          end
        end else begin
          m_left--;
          if (m_left == 0) m_lock = 0;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic set_a(int c, bit v, logic [2:0] op,
                       logic [2:0] sz, logic [4:0] src);
    a_v[c] = v; a_op[c] = op; a_sz[c] = sz; a_src[c] = src;
    a_par[c] = 3'($urandom); a_adr[c] = 29'($urandom);
    a_msk[c] = 8'($urandom); a_dat[c] = {$urandom, $urandom};
    a_cor[c] = 1'($urandom);
  endtask

  task automatic rand_d();
    out_d_valid = 1'($urandom); d_src = 6'($urandom);
    d_rdy[0] = 1'($urandom); d_rdy[1] = 1'($urandom);
    d_op = 3'($urandom); d_par = 2'($urandom);
    d_sz = 3'($urandom); d_sink = 1'($urandom);
    d_den = 1'($urandom); d_cor = 1'($urandom);
    d_dat = {$urandom, $urandom};
  endtask

  int fires;

  initial begin
    reset = 1'b0;
    model_reset();
    set_a(0, 0, GET, 3, 0);
    set_a(1, 0, GET, 3, 0);
    out_a_ready = 1'b0;
    rand_d();
    @(negedge clock);
    check("rst_a_valid", out_a_valid, 1'b0);
    cycle();
    reset = 1'b1;

    // Alternating Gets from both clients.
    for (int i = 0; i < 4; i++) begin
      set_a(0, 1, GET, 3, 5'h07);
      set_a(1, 1, GET, 3, 5'h1A);
      out_a_ready = 1'b1;
      rand_d();
      #1;
      check("alt_src", out_a_bits_source,
            (i % 2) ? 6'h3A : 6'h07);
      cycle();
    end

    // Eight-beat PutFull from client 0 blocks client 1.
    for (int i = 0; i < 9; i++) begin
      set_a(0, 1, PUT_FULL, 6, 5'h03);
      set_a(1, 1, GET, 3, 5'h11);
      out_a_ready = 1'b1;
      rand_d();
      #1;
      check("burst8_rdy1", in1_a_ready, i == 8);
      check("burst8_who", out_a_bits_source[5], i == 8);
      cycle();
    end

    // Four-beat PutFull with a throttled sink.
    fires = 0;
    for (int i = 0; i < 9; i++) begin
      set_a(0, 1, PUT_FULL, 5, 5'h04);
      set_a(1, 1, GET, 3, 5'h12);
      out_a_ready = (i % 2 == 1) || i == 8;
      rand_d();
      #1;
      check("burst4_who", out_a_bits_source[5], i == 8);
      if (out_a_valid && out_a_ready && !out_a_bits_source[5]) fires++;
      cycle();
    end
    check("burst4_fires", fires, 4);

    // D routing by tag with the target client stalled.
    out_d_valid = 1'b1; d_src = 6'h25;
    d_rdy[0] = 1'b1; d_rdy[1] = 1'b0;
    set_a(0, 0, GET, 3, 0);
    set_a(1, 0, GET, 3, 0);
    #1;
    check("d25_vld1", in1_d_valid, 1'b1);
    check("d25_src1", in1_d_bits_source, 5'h05);
    check("d25_vld0", in0_d_valid, 1'b0);
    check("d25_rdy", out_d_ready, 1'b0);
    d_rdy[1] = 1'b1;
    #1;
    check("d25_rdy_on", out_d_ready, 1'b1);
    cycle();

    // Reset in the middle of an eight-beat burst.
    for (int i = 0; i < 3; i++) begin
      set_a(0, 1, PUT_PARTIAL, 6, 5'h09);
      set_a(1, 0, GET, 3, 5'h13);
      out_a_ready = 1'b1;
      rand_d();
      cycle();
    end
    reset = 1'b0;
    set_a(0, 0, PUT_PARTIAL, 6, 5'h09);
    set_a(1, 1, GET, 3, 5'h13);
    #1;
    check("rst_idle_vld", out_a_valid, 1'b1);
    check("rst_idle_who", out_a_bits_source, 6'h33);
    set_a(0, 1, PUT_PARTIAL, 6, 5'h09);
    #1;
    check("rst_prio0", out_a_bits_source[5], 1'b0);
    cycle();
    reset = 1'b1;
    set_a(0, 0, PUT_PARTIAL, 6, 5'h09);
    set_a(1, 1, GET, 3, 5'h13);
    #1;
    check("post_rst_rdy1", in1_a_ready, 1'b1);
    cycle();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < 2; c++)
        set_a(c, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 2) == 0) ? GET : 3'($urandom),
              3'($urandom_range(0, 6)), 5'($urandom));
      out_a_ready = ($urandom_range(0, 3) != 0);
      rand_d();
      cycle();
    end
    reset = 1'b1;

`ifdef TL_ARB_PERF_EN
    #1;
    check("perf_g0", perf_grants0, 32'(m_g[0]));
    check("perf_g1", perf_grants1, 32'(m_g[1]));
    check("perf_cont", perf_contend, 32'(m_cont));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
